// File: rtl/data_mem_responder.sv
// Data-memory responder for the M stage: word-addressed 32-bit array behind a
// request/response handshake with a fixed, parameterised access latency.
// Latency: LATENCY cycles from acceptance to the rsp_valid pulse (posted stores: 1).
// Backpressure: req_ready is low while an access is in flight (and, with the
// write buffer, to a store while the buffer is occupied); stall_o freezes the
// M stage and everything upstream while an access is outstanding.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-high reset (aborts in-flight access,
//                array contents are kept)
//   req_valid  - M stage presents an access
//   req_write  - 1 = store, 0 = load
//   req_addr   - word address (8 bits)
//   req_wdata  - store data
//   req_ready  - access accepted on this edge when req_valid is also 1
//   rsp_valid  - one-cycle completion pulse for loads and stores
//   rsp_rdata  - load data while rsp_valid for a load, otherwise 0
//   stall_o    - hold request to the hazard unit
//
// Parameters: DEPTH (words in the array, at most 256), LATENCY (1..15).
// Optional feature: define DMEM_WBUF_EN to add a one-entry posted write
// buffer. Without it, stores commit on the edge leaving their RESP cycle.

module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        stall_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic [3:0]    cnt_nxt;

    // Access captured at acceptance; later changes on the request bus are ignored.
    logic          op_write;
    logic [7:0]    op_addr;
    logic          op_in_range;

    logic [31:0]   mem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    logic          ready_int;
    logic          accept;
    logic          fast_path;   // response comes on the cycle right after acceptance

`ifdef DMEM_WBUF_EN
    logic          wb_vld;
    logic [7:0]    wb_addr;
    logic [31:0]   wb_data;
    logic [3:0]    wb_cnt;
    logic          wb_drain;

    // The buffer commits to the array LATENCY cycles after the store was
    // accepted, i.e. on the same edge an unbuffered store would have.
    assign wb_drain  = wb_vld && (wb_cnt == 4'd0);

    // Only one store can be posted at a time; loads are never held off by it.
    assign ready_int = ((state == IDLE) || (state == RESP)) && !(req_write && wb_vld);

    // Posted stores are acknowledged immediately.
    assign fast_path = (LATENCY == 1) || req_write;

    assign mem_we    = wb_drain && ({24'd0, wb_addr} < DEPTH_W);
    assign mem_waddr = wb_addr[AW-1:0];
    assign mem_wdata = wb_data;
`else
    logic [31:0]   op_wdata;

    assign ready_int = (state == IDLE) || (state == RESP);
    assign fast_path = (LATENCY == 1);

    // Store commits on the edge leaving RESP, so a load accepted during the
    // RESP cycle already sees the new value. Reset forces IDLE asynchronously,
    // so an aborted store can never reach this point.
    assign mem_we    = (state == RESP) && op_write && op_in_range;
    assign mem_waddr = op_addr[AW-1:0];
    assign mem_wdata = op_wdata;
`endif

    assign accept      = req_valid && ready_int;
    assign op_in_range = ({24'd0, op_addr} < DEPTH_W);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            op_write <= 1'b0;
            op_addr  <= 8'd0;
`ifndef DMEM_WBUF_EN
            op_wdata <= 32'd0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                op_write <= req_write;
                op_addr  <= req_addr;
`ifndef DMEM_WBUF_EN
                op_wdata <= req_wdata;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and latency counter
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    cnt_nxt   = fast_path ? 4'd0 : LAT_M1;
                    state_nxt = fast_path ? RESP : WAIT;
                end else if (state == RESP) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    always_comb begin
        rsp_rdata = 32'd0;
        if ((state == RESP) && !op_write && op_in_range) begin
            rsp_rdata = mem[op_addr[AW-1:0]];
`ifdef DMEM_WBUF_EN
            if (wb_vld && (wb_addr == op_addr)) begin
                rsp_rdata = wb_data;
            end
`endif
        end
    end

    assign req_ready = ready_int;
    assign rsp_valid = (state == RESP);

    // A request presented during RESP is either the one completing or is
    // taken in that same cycle, so RESP only holds the pipeline when the
    // presented request is refused (a store meeting a full write buffer).
    assign stall_o = (req_valid && (state == IDLE))
                   || (state == WAIT)
                   || (req_valid && (state == RESP) && !ready_int);

    // ------------------------------------------------------------------
    // Array: no reset, contents survive rst
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

`ifdef DMEM_WBUF_EN
    // ------------------------------------------------------------------
    // One-entry posted write buffer; reset discards an undrained store.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_vld  <= 1'b0;
            wb_addr <= 8'd0;
            wb_data <= 32'd0;
            wb_cnt  <= 4'd0;
        end else if (accept && req_write) begin
            wb_vld  <= 1'b1;
            wb_addr <= req_addr;
            wb_data <= req_wdata;
            wb_cnt  <= LAT_M1;
        end else if (wb_drain) begin
            wb_vld  <= 1'b0;
        end else if (wb_vld) begin
            wb_cnt  <= wb_cnt - 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances (LATENCY 1, 2, 3,
// DEPTH 128 so address 0x80 is out of range) sharing clock and reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.

module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        rv [3];
    logic        rw [3];
    logic [7:0]  ra [3];
    logic [31:0] wd [3];
    logic        rr [3];
    logic        vo [3];
    logic [31:0] rd [3];
    logic        so [3];

    int n_checks = 0;
    int n_errors = 0;

    data_mem_responder #(.DEPTH(128), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_write(rw[0]), .req_addr(ra[0]),
        .req_wdata(wd[0]), .req_ready(rr[0]), .rsp_valid(vo[0]), .rsp_rdata(rd[0]), .stall_o(so[0])
    );
    data_mem_responder #(.DEPTH(128), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_write(rw[1]), .req_addr(ra[1]),
        .req_wdata(wd[1]), .req_ready(rr[1]), .rsp_valid(vo[1]), .rsp_rdata(rd[1]), .stall_o(so[1])
    );
    data_mem_responder #(.DEPTH(128), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .req_valid(rv[2]), .req_write(rw[2]), .req_addr(ra[2]),
        .req_wdata(wd[2]), .req_ready(rr[2]), .rsp_valid(vo[2]), .rsp_rdata(rd[2]), .stall_o(so[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request, wait for acceptance, then count cycles to rsp_valid.
    // Returns in the RESP cycle (edge + 2).
    task automatic do_req(input int i, input logic w, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] data, output int lat);
        bit done;
        rv[i] = 1'b1; rw[i] = w; ra[i] = a; wd[i] = d;
        data = 32'd0; lat = 0; done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            #1;
            if (rr[i] === 1'b1) done = 1'b1;
            step();
        end
        rv[i] = 1'b0;
        check("req_accepted", 32'(done), 32'd1);
        if (!done) return;
        done = 1'b0;
        for (int n = 1; n <= 20 && !done; n++) begin
            #1;
            if (vo[i] === 1'b1) begin
                done = 1'b1;
                lat  = n;
                data = rd[i];
            end else begin
                step();
            end
        end
        check("rsp_seen", 32'(done), 32'd1);
    endtask

    task automatic wr(input int i, input logic [7:0] a, input logic [31:0] d, input string tag);
        logic [31:0] r;
        int          lat;
        do_req(i, 1'b1, a, d, r, lat);
        check({tag, "_st_rdata"}, r, 32'd0);
        step();
    endtask

    task automatic rd_chk(input int i, input logic [7:0] a, input logic [31:0] exp,
                          input int exp_lat, input string tag);
        logic [31:0] r;
        int          lat;
        do_req(i, 1'b0, a, 32'd0, r, lat);
        check({tag, "_data"}, r, exp);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        int          lat;
        int          pulses;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = 8'd0; wd[i] = 32'd0;
        end
        #2;
        // Reset state
        for (int i = 0; i < 3; i++) begin
            check("rst_ready", 32'(rr[i]), 32'd1);
            check("rst_rsp_valid", 32'(vo[i]), 32'd0);
            check("rst_rdata", rd[i], 32'd0);
            check("rst_stall", 32'(so[i]), 32'd0);
        end
        step();
        step();
        rst = 1'b0;

        // Store 0x10 then back-to-back load of 0x10 (LATENCY 2)
`ifndef DMEM_WBUF_EN
        rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 8'h10; wd[1] = 32'hDEADBEEF;
        #1;
        check("a_t0_ready", 32'(rr[1]), 32'd1);
        check("a_t0_stall", 32'(so[1]), 32'd1);
        check("a_t0_valid", 32'(vo[1]), 32'd0);
        step();
        rv[1] = 1'b0;
        #1;
        check("a_t1_valid", 32'(vo[1]), 32'd0);
        check("a_t1_stall", 32'(so[1]), 32'd1);
        check("a_t1_ready", 32'(rr[1]), 32'd0);
        step();
        rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 8'h10; wd[1] = 32'd0;
        #1;
        check("a_t2_valid", 32'(vo[1]), 32'd1);
        check("a_t2_rdata", rd[1], 32'd0);
        check("a_t2_ready", 32'(rr[1]), 32'd1);
        check("a_t2_stall", 32'(so[1]), 32'd0);
        step();
        rv[1] = 1'b0;
        #1;
        check("a_t3_valid", 32'(vo[1]), 32'd0);
        step();
        #1;
        check("a_t4_valid", 32'(vo[1]), 32'd1);
        check("a_t4_rdata", rd[1], 32'hDEADBEEF);
        step();
        #1;
        check("a_t5_valid", 32'(vo[1]), 32'd0);
        check("a_t5_stall", 32'(so[1]), 32'd0);
        step();
`else
        do_req(1, 1'b1, 8'h10, 32'hDEADBEEF, r, lat);
        check("a_st_lat", 32'(lat), 32'd1);
        step();
        rd_chk(1, 8'h10, 32'hDEADBEEF, 2, "a_ld");
`endif

        // Request bus changes after acceptance are ignored (LATENCY 2)
        wr(1, 8'h44, 32'h44444444, "d_w44");
        wr(1, 8'h55, 32'h55555555, "d_w55");
        step(); step(); step();
        rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 8'h44;
        #1;
        check("d_t0_ready", 32'(rr[1]), 32'd1);
        step();
        ra[1] = 8'h55;
        #1;
        check("d_t1_stall", 32'(so[1]), 32'd1);
        check("d_t1_ready", 32'(rr[1]), 32'd0);
        step();
        #1;
        check("d_t2_valid", 32'(vo[1]), 32'd1);
        check("d_t2_rdata", rd[1], 32'h44444444);
        check("d_t2_ready", 32'(rr[1]), 32'd1);
        step();
        rv[1] = 1'b0;
        step();
        #1;
        check("d_t4_valid", 32'(vo[1]), 32'd1);
        check("d_t4_rdata", rd[1], 32'h55555555);
        step();

        // Out-of-range address: store dropped (no aliasing), load returns 0
        wr(1, 8'h00, 32'h0000C0DE, "e_w00");
        wr(1, 8'h80, 32'hFFFFFFFF, "e_w80");
        rd_chk(1, 8'h80, 32'd0, 2, "e_ld80");
        rd_chk(1, 8'h00, 32'h0000C0DE, 2, "e_ld00");

        // LATENCY 1: four back-to-back loads, one response per cycle
        for (int k = 0; k < 4; k++) wr(0, 8'(k), 32'h10000000 + 32'(k), "b_wr");
        step(); step();
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 8'd0;
        #1;
        check("b_c0_stall", 32'(so[0]), 32'd1);
        check("b_c0_ready", 32'(rr[0]), 32'd1);
        step();
        for (int k = 1; k < 4; k++) begin
            ra[0] = 8'(k);
            #1;
            check("b_valid", 32'(vo[0]), 32'd1);
            check("b_rdata", rd[0], 32'h10000000 + 32'(k - 1));
            check("b_stall", 32'(so[0]), 32'd0);
            step();
        end
        rv[0] = 1'b0;
        #1;
        check("b_c4_valid", 32'(vo[0]), 32'd1);
        check("b_c4_rdata", rd[0], 32'h10000003);
        check("b_c4_stall", 32'(so[0]), 32'd0);
        step();
        #1;
        check("b_c5_valid", 32'(vo[0]), 32'd0);
        step();

        // LATENCY 3: reset aborts an in-flight store
        wr(2, 8'h20, 32'hA5A50020, "c_w20");
        rv[2] = 1'b1; rw[2] = 1'b1; ra[2] = 8'h20; wd[2] = 32'hBAD0BAD0;
        for (int n = 0; n < 10 && rr[2] !== 1'b1; n++) step();
        #1;
        check("c_t0_ready", 32'(rr[2]), 32'd1);
        step();
        rv[2] = 1'b0;
        rst = 1'b1;
        #1;
        check("c_rst_ready", 32'(rr[2]), 32'd1);
        check("c_rst_valid", 32'(vo[2]), 32'd0);
        check("c_rst_stall", 32'(so[2]), 32'd0);
        step();
        rst = 1'b0;
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            #1;
            if (vo[2] === 1'b1) pulses++;
            step();
        end
        check("c_no_rsp", 32'(pulses), 32'd0);
        #1;
        check("c_ready_after", 32'(rr[2]), 32'd1);
        step();
        rd_chk(2, 8'h20, 32'hA5A50020, 3, "c_ld20");

`ifdef DMEM_WBUF_EN
        // Posted store: ack next cycle, load behind it sees the data
        step(); step(); step(); step();
        rv[2] = 1'b1; rw[2] = 1'b1; ra[2] = 8'h30; wd[2] = 32'h12345678;
        #1;
        check("f_t0_ready", 32'(rr[2]), 32'd1);
        step();
        rw[2] = 1'b0;
        #1;
        check("f_t1_ack", 32'(vo[2]), 32'd1);
        check("f_t1_ready", 32'(rr[2]), 32'd1);
        step();
        rv[2] = 1'b0;
        step(); step();
        #1;
        check("f_t4_valid", 32'(vo[2]), 32'd1);
        check("f_t4_rdata", rd[2], 32'h12345678);
        step(); step(); step(); step();
        // Second store while the buffer is full
        rv[2] = 1'b1; rw[2] = 1'b1; ra[2] = 8'h31; wd[2] = 32'h00000001;
        #1;
        check("g_t0_ready", 32'(rr[2]), 32'd1);
        step();
        ra[2] = 8'h32; wd[2] = 32'h00000002;
        #1;
        check("g_t1_ack", 32'(vo[2]), 32'd1);
        check("g_t1_ready", 32'(rr[2]), 32'd0);
        check("g_t1_stall", 32'(so[2]), 32'd1);
        step();
        for (int n = 2; n < 4; n++) begin
            #1;
            check("g_full_ready", 32'(rr[2]), 32'd0);
            check("g_full_stall", 32'(so[2]), 32'd1);
            step();
        end
        #1;
        check("g_t4_ready", 32'(rr[2]), 32'd1);
        step();
        rv[2] = 1'b0;
        #1;
        check("g_t5_ack", 32'(vo[2]), 32'd1);
        step();
        rd_chk(2, 8'h32, 32'h00000002, 3, "g_ld32");
        rd_chk(2, 8'h31, 32'h00000001, 3, "g_ld31");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
